// File: rtl/seq_timer_ctrl_if.sv
// Bus bundle for seq_timer_ctrl: duration-register configuration, run
// control (nsteps/loops/arm/trig/abort) and the registered status outputs.
// The controller uses the slave modport; whatever drives it uses master.
interface seq_timer_ctrl_if #(
    parameter int CW = 32,
    parameter int SW = 2
);
    // Configuration write port for the duration registers
    logic           cfg_we;
    logic [SW-1:0]  cfg_addr;
    logic [CW-1:0]  cfg_data;

    // Run parameters, sampled into shadows when a trigger is accepted
    logic [SW:0]    nsteps;
    logic [15:0]    loops;

    // Run control
    logic           arm;
    logic           trig;
    logic           abort;

    // Status
    logic           armed;
    logic           busy;
    logic [SW-1:0]  step;
    logic           step_strobe;
    logic           done;
    logic [15:0]    loop_cnt;

    modport master (
        output cfg_we, cfg_addr, cfg_data, nsteps, loops, arm, trig, abort,
        input  armed, busy, step, step_strobe, done, loop_cnt
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, nsteps, loops, arm, trig, abort,
        output armed, busy, step, step_strobe, done, loop_cnt
    );
endinterface

// File: rtl/seq_timer_ctrl.sv
// Step sequencer: walks a shared cycle counter through up to NSTEPS timed
// steps, optionally repeating the list a programmed number of times (or
// forever). Software arms it, a trigger starts the run, abort returns to
// idle. Step k holds for shadow_dur[k]+1 cycles with no dead cycles between
// steps or loops. All status outputs come straight from registers.
module seq_timer_ctrl #(
    parameter int CW     = 32,
    parameter int NSTEPS = 4,
    parameter int SW     = 2
) (
    input  logic             clk,
    input  logic             rst,
    seq_timer_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t          state_reg, state_next;

    // Live duration registers (software view) and the per-run copies
    logic [CW-1:0]   dur_reg        [NSTEPS];
    logic [CW-1:0]   shadow_dur_reg [NSTEPS];
    logic [NSTEPS-1:0] dur_we;

    logic [SW:0]     shadow_nsteps_reg;
    logic [15:0]     shadow_loops_reg;

    logic [CW-1:0]   counter_reg, counter_next;
    logic [SW-1:0]   step_reg, step_next;
    logic            strobe_reg, strobe_next;
    logic            done_reg, done_next;
    logic [15:0]     loop_cnt_reg, loop_cnt_next;
    logic            armed_reg, armed_next;
    logic            busy_reg, busy_next;

    // Run-time decode helpers
    logic            latch_shadow;
    logic [SW:0]     nsteps_clamped;
    logic [CW-1:0]   cur_dur;
    logic            step_is_last;
    logic [15:0]     loop_inc;
    logic            loop_more;

    // Per-register write enables decoded from the config address
    genvar gi;
    generate
        for (gi = 0; gi < NSTEPS; gi++) begin : g_dur_we
            assign dur_we[gi] = bus.cfg_we && (bus.cfg_addr == SW'(gi));
        end
    endgenerate

    // Duration registers accept writes in any state; shadows copy them only
    // when a trigger is accepted, so writes during a run hit the next run.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSTEPS; i++) begin
                dur_reg[i]        <= '0;
                shadow_dur_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSTEPS; i++) begin
                if (dur_we[i]) begin
                    dur_reg[i] <= bus.cfg_data;
                end
                if (latch_shadow) begin
                    shadow_dur_reg[i] <= dur_reg[i];
                end
            end
        end
    end

    // Clamp requested step count into 1..NSTEPS (0 means one step)
    always_comb begin
        nsteps_clamped = bus.nsteps;
        if (bus.nsteps == '0) begin
            nsteps_clamped = (SW+1)'(1);
        end else if (bus.nsteps > (SW+1)'(NSTEPS)) begin
            nsteps_clamped = (SW+1)'(NSTEPS);
        end
    end

    // Capture step count and loop count for the run being started
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_nsteps_reg <= (SW+1)'(1);
            shadow_loops_reg  <= '0;
        end else if (latch_shadow) begin
            shadow_nsteps_reg <= nsteps_clamped;
            shadow_loops_reg  <= bus.loops;
        end
    end

    // The counter is only ever compared for equality against the current
    // step's duration, so an all-ones duration runs its full 2^CW cycles.
    assign cur_dur      = shadow_dur_reg[step_reg];
    assign step_is_last = (({1'b0, step_reg} + (SW+1)'(1)) >= shadow_nsteps_reg);
    assign loop_inc     = loop_cnt_reg + 16'd1;
    assign loop_more    = (shadow_loops_reg == 16'd0) || (loop_inc < shadow_loops_reg);

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            counter_reg  <= '0;
            step_reg     <= '0;
            strobe_reg   <= 1'b0;
            done_reg     <= 1'b0;
            loop_cnt_reg <= '0;
            armed_reg    <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            counter_reg  <= counter_next;
            step_reg     <= step_next;
            strobe_reg   <= strobe_next;
            done_reg     <= done_next;
            loop_cnt_reg <= loop_cnt_next;
            armed_reg    <= armed_next;
            busy_reg     <= busy_next;
        end
    end

    // Next-state and next-output decode; abort wins over arm and trigger
    always_comb begin
        state_next    = state_reg;
        counter_next  = counter_reg;
        step_next     = step_reg;
        strobe_next   = 1'b0;
        done_next     = 1'b0;
        loop_cnt_next = loop_cnt_reg;
        latch_shadow  = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                // Trigger is ignored here; arm alone decides the move
                if (bus.abort) begin
                    state_next = ST_IDLE;
                end else if (bus.arm) begin
                    state_next = ST_ARMED;
                end
            end

            ST_ARMED: begin
                if (bus.abort) begin
                    state_next = ST_IDLE;
                end else if (bus.trig) begin
                    state_next    = ST_RUN;
                    latch_shadow  = 1'b1;
                    counter_next  = '0;
                    step_next     = '0;
                    strobe_next   = 1'b1;
                    loop_cnt_next = '0;
                end
            end

            ST_RUN: begin
                if (bus.abort) begin
                    // Step index and loop count stay visible after abort
                    state_next = ST_IDLE;
                end else if (counter_reg != cur_dur) begin
                    counter_next = counter_reg + CW'(1);
                end else if (!step_is_last) begin
                    step_next    = step_reg + SW'(1);
                    counter_next = '0;
                    strobe_next  = 1'b1;
                end else if (loop_more) begin
                    // Infinite mode lets loop_cnt wrap naturally at 16 bits
                    loop_cnt_next = loop_inc;
                    step_next     = '0;
                    counter_next  = '0;
                    strobe_next   = 1'b1;
                end else begin
                    loop_cnt_next = loop_inc;
                    state_next    = ST_IDLE;
                    done_next     = 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        armed_next = (state_next == ST_ARMED);
        busy_next  = (state_next == ST_RUN);
    end

    assign bus.armed       = armed_reg;
    assign bus.busy        = busy_reg;
    assign bus.step        = step_reg;
    assign bus.step_strobe = strobe_reg;
    assign bus.done        = done_reg;
    assign bus.loop_cnt    = loop_cnt_reg;

endmodule

// File: tb/tb_seq_timer_ctrl.sv
// Bench for seq_timer_ctrl. Stimulus pushes expected strobe/done events into
// a queue before each run; a monitor pops one entry every cycle the DUT shows
// a strobe or done and compares time, step, loop count and busy. State-level
// checks (armed/idle/hold rules) are made directly by the stimulus process.
module tb_seq_timer_ctrl;

    localparam int CW     = 32;
    localparam int NSTEPS = 4;
    localparam int SW     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Cycle number; stable whenever sampled on the falling edge
    always @(posedge clk) cyc <= cyc + 1;

    seq_timer_ctrl_if #(.CW(CW), .SW(SW)) bus ();

    seq_timer_ctrl #(.CW(CW), .NSTEPS(NSTEPS), .SW(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int              cyc;
        bit              is_done;
        logic [SW-1:0]   step;
        logic [15:0]     loop_cnt;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic push_ev(input int c, input bit d, input logic [SW-1:0] s,
                           input logic [15:0] l);
        ev_t e;
        e.cyc = c; e.is_done = d; e.step = s; e.loop_cnt = l;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe or done must match the head of the queue
    always @(negedge clk) begin
        if (bus.step_strobe || bus.done) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: cyc=%0d strobe=%0b done=%0b step=%0d loop=%0d, required none",
                         cyc, bus.step_strobe, bus.done, bus.step, bus.loop_cnt);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.is_done != bus.done || bus.step_strobe == bus.done ||
                    e.step != bus.step || e.loop_cnt != bus.loop_cnt || bus.busy == e.is_done) begin
                    bad++;
                    $display("FAIL event: got cyc=%0d done=%0b strobe=%0b step=%0d loop=%0d busy=%0b, required cyc=%0d done=%0b step=%0d loop=%0d",
                             cyc, bus.done, bus.step_strobe, bus.step, bus.loop_cnt, bus.busy,
                             e.cyc, e.is_done, e.step, e.loop_cnt);
                end else begin
                    $display("event cyc=%0d %s step=%0d loop=%0d ok", cyc,
                             e.is_done ? "done" : "strobe", e.step, e.loop_cnt);
                end
            end
        end
    end

    task automatic check_outs(input string name, input logic a, input logic b,
                              input logic [SW-1:0] s, input logic st, input logic d,
                              input logic [15:0] lc);
        logic [SW+19:0] act, req;
        act = {bus.armed, bus.busy, bus.step, bus.step_strobe, bus.done, bus.loop_cnt};
        req = {a, b, s, st, d, lc};
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got armed=%0b busy=%0b step=%0d strobe=%0b done=%0b loop=%0d, required armed=%0b busy=%0b step=%0d strobe=%0b done=%0b loop=%0d",
                     name, bus.armed, bus.busy, bus.step, bus.step_strobe, bus.done, bus.loop_cnt,
                     a, b, s, st, d, lc);
        end else begin
            $display("check %s ok", name);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [SW-1:0] a, input logic [CW-1:0] v);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = v;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic do_arm();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
    endtask

    task automatic do_trig();
        bus.trig = 1'b1;
        tick();
        bus.trig = 1'b0;
    endtask

    initial begin
        int t;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.nsteps = '0;   bus.loops = '0;
        bus.arm = 1'b0;    bus.trig = 1'b0; bus.abort = 1'b0;

        repeat (3) tick();
        check_outs("reset", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
        rst = 1'b0;

        cfg_write(2'd0, 32'd2);
        cfg_write(2'd1, 32'd0);
        cfg_write(2'd2, 32'd5);
        cfg_write(2'd3, 32'd1);
        bus.nsteps = 3'd3; bus.loops = 16'd1;

        // Trigger in IDLE is ignored; arm+trig together only arms
        do_trig();
        check_outs("trig_in_idle", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
        bus.arm = 1'b1; bus.trig = 1'b1;
        tick();
        bus.arm = 1'b0; bus.trig = 1'b0;
        check_outs("arm_trig_idle", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);

        // Single shot: dur={2,0,5,1}, 3 steps, 1 loop
        t = cyc;
        push_ev(t+1, 0, 2'd0, 16'd0);
        push_ev(t+4, 0, 2'd1, 16'd0);
        push_ev(t+5, 0, 2'd2, 16'd0);
        push_ev(t+11, 1, 2'd2, 16'd1);
        do_trig();
        wait_to(t+3);
        do_arm();
        check_outs("arm_in_run", 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 16'd0);
        wait_to(t+10);
        check_outs("single_last_cycle", 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 16'd0);
        wait_to(t+11);
        check_outs("single_done", 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 16'd1);
        wait_to(t+12);
        check_outs("single_after", 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 16'd1);

        // Two loops; dur[1]=9 written mid-run must not affect this run
        bus.loops = 16'd2;
        do_arm();
        check_outs("armed_holds", 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 16'd1);
        t = cyc;
        push_ev(t+1,  0, 2'd0, 16'd0);
        push_ev(t+4,  0, 2'd1, 16'd0);
        push_ev(t+5,  0, 2'd2, 16'd0);
        push_ev(t+11, 0, 2'd0, 16'd1);
        push_ev(t+14, 0, 2'd1, 16'd1);
        push_ev(t+15, 0, 2'd2, 16'd1);
        push_ev(t+21, 1, 2'd2, 16'd2);
        do_trig();
        check_outs("run_start", 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 16'd0);
        wait_to(t+2);
        cfg_write(2'd1, 32'd9);
        wait_to(t+11);
        check_outs("loop_wrap", 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 16'd1);
        wait_to(t+22);
        check_outs("two_after", 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 16'd2);

        // Next run picks up dur[1]=9; re-arm on the done cycle
        bus.loops = 16'd1;
        do_arm();
        t = cyc;
        push_ev(t+1,  0, 2'd0, 16'd0);
        push_ev(t+4,  0, 2'd1, 16'd0);
        push_ev(t+14, 0, 2'd2, 16'd0);
        push_ev(t+20, 1, 2'd2, 16'd1);
        do_trig();
        wait_to(t+20);
        do_arm();
        check_outs("rearm_at_done", 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 16'd1);

        // nsteps=0 behaves as one step per loop
        bus.nsteps = 3'd0; bus.loops = 16'd2;
        t = cyc;
        push_ev(t+1, 0, 2'd0, 16'd0);
        push_ev(t+4, 0, 2'd0, 16'd1);
        push_ev(t+7, 1, 2'd0, 16'd2);
        do_trig();
        wait_to(t+9);
        check_outs("nsteps0_after", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd2);

        // nsteps=7 clamps to four steps: dur={2,9,5,1}
        bus.nsteps = 3'd7; bus.loops = 16'd1;
        do_arm();
        t = cyc;
        push_ev(t+1,  0, 2'd0, 16'd0);
        push_ev(t+4,  0, 2'd1, 16'd0);
        push_ev(t+14, 0, 2'd2, 16'd0);
        push_ev(t+20, 0, 2'd3, 16'd0);
        push_ev(t+22, 1, 2'd3, 16'd1);
        do_trig();
        wait_to(t+24);
        check_outs("nsteps7_after", 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 16'd1);

        // Abort together with trigger in ARMED returns to IDLE
        do_arm();
        bus.abort = 1'b1; bus.trig = 1'b1;
        tick();
        bus.abort = 1'b0; bus.trig = 1'b0;
        check_outs("abort_trig_armed", 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 16'd1);
        do_trig();
        check_outs("trig_after_abort", 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 16'd1);

        // Infinite loop of one 4-cycle step, aborted 50 cycles after trigger
        cfg_write(2'd0, 32'd3);
        bus.nsteps = 3'd1; bus.loops = 16'd0;
        do_arm();
        t = cyc;
        for (int k = 0; k <= 12; k++) begin
            push_ev(t+1+4*k, 0, 2'd0, 16'(k));
        end
        do_trig();
        wait_to(t+49);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_outs("abort_infinite", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd12);
        wait_to(t+56);
        check_outs("abort_hold", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd12);

        // Reset during step 2: dur={3,9,5,1}
        bus.nsteps = 3'd3; bus.loops = 16'd1;
        do_arm();
        t = cyc;
        push_ev(t+1,  0, 2'd0, 16'd0);
        push_ev(t+5,  0, 2'd1, 16'd0);
        push_ev(t+15, 0, 2'd2, 16'd0);
        do_trig();
        wait_to(t+16);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outs("reset_mid_run", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
        do_trig();
        check_outs("trig_without_arm", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);

        // Cleared durations give a 1-cycle step
        bus.nsteps = 3'd1; bus.loops = 16'd1;
        do_arm();
        t = cyc;
        push_ev(t+1, 0, 2'd0, 16'd0);
        push_ev(t+2, 1, 2'd0, 16'd1);
        do_trig();
        wait_to(t+4);
        check_outs("cleared_dur_after", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd1);

        repeat (4) tick();
        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_event: got none, required cyc=%0d done=%0b step=%0d loop=%0d",
                     e.cyc, e.is_done, e.step, e.loop_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_timer_ctrl.md
Name: seq_timer_ctrl

Overview:
- Controller that sequences a shared cycle counter through a programmable list of timed steps.
- Used for pulse, sweep and gate timing: software arms the block, an external trigger starts the run, and each step holds for a programmed number of cycles.
- Downstream logic uses the step index and the per-step strobe to switch outputs and setpoints.
- Supports single-shot, N-loop and infinite-loop runs, with abort.

Parameters:
- CW, 32, width of the step-duration registers and the internal counter
- NSTEPS, 4, number of step-duration registers (power of two)
- SW, 2, log2(NSTEPS); width of the step index

Ports:
- clk_i  in  1  system clock; all logic on rising edge
- rst_i  in  1  synchronous reset, active-high
- cfg_we_i  in  1  write strobe for the duration registers
- cfg_addr_i  in  SW  duration register index
- cfg_data_i  in  CW  duration value; step lasts value+1 cycles
- nsteps_i  in  SW+1  number of active steps, 1..NSTEPS; 0 treated as 1; values >NSTEPS treated as NSTEPS
- loops_i  in  16  loop count; 0 = infinite
- arm_i  in  1  arm request (level or pulse)
- trig_i  in  1  start trigger
- abort_i  in  1  abort request
- armed_o  out  1  high in ARMED
- busy_o  out  1  high in RUN
- step_o  out  SW  current step index
- step_strobe_o  out  1  1-cycle pulse on the first cycle of every step
- done_o  out  1  1-cycle pulse on normal completion
- loop_cnt_o  out  16  completed loops in the current or last run

Behaviour:
- **Outputs.** All outputs are registered.
- **Reset.** rst_i=1 forces:
  - state IDLE
  - all outputs 0, including loop_cnt_o
  - duration registers and shadows 0
  - counter 0
- **Reset mid-run.** Same as reset; it takes effect on the next edge.
- **Config writes.** Accepted in any state. dur[cfg_addr_i] <= cfg_data_i.
- **Latching at trigger.** On trigger acceptance the block copies dur[], the clamped nsteps_i and loops_i into shadow registers. A run uses only the shadows. Writes during RUN affect the next run only.
- **IDLE.**
  - arm_i=1 -> ARMED; armed_o goes high next cycle.
  - trig_i is ignored in IDLE.
  - arm_i and trig_i together -> arm only.
- **ARMED.**
  - trig_i=1 at edge t -> RUN. At t+1: busy_o=1, armed_o=0, step_o=0, step_strobe_o=1, loop_cnt_o=0, counter=0.
  - arm_i is ignored in ARMED.
- **RUN.**
  - Each cycle, if counter != shadow_dur[step]: counter+1.
  - Otherwise the step ends, and one of three things happens next cycle:
    - step < nsteps-1: step+1, counter=0, strobe.
    - Last step with loops continuing (shadow_loops==0, or loop_cnt+1 < shadow_loops): loop_cnt+1, step=0, counter=0, strobe.
    - Last step of the final loop: loop_cnt+1, state IDLE, busy_o=0, done_o=1 for exactly that one cycle.
  - Step k occupies exactly shadow_dur[k]+1 cycles; a duration of 0 gives a 1-cycle step.
  - There is no dead cycle between steps or loops.
- **Infinite mode.** loop_cnt_o wraps from 0xFFFF to 0.
- **Abort.**
  - abort_i=1 in any state -> IDLE next cycle.
  - busy_o=0, armed_o=0, step_strobe_o=0, done_o=0 (no done pulse).
  - step_o and loop_cnt_o hold their values.
  - Abort has priority over trig_i and arm_i in the same cycle.
- **After completion or abort.** step_o and loop_cnt_o hold until the next trigger. step_o=0 only at trigger.
- **Comparison width.** The counter is CW bits and is never compared beyond shadow_dur, so an all-ones duration runs for 2^CW cycles without wrap error.
- **Re-arm timing.** The earliest re-arm is the cycle done_o is high: arm_i is sampled in IDLE.

Test Plan:
- **Single shot.**
  - Stimulus: dur={2,0,5,1}, nsteps_i=3, loops_i=1, arm, then trig at edge t.
  - Response: strobes at t+1 (step 0), t+4 (step 1), t+5 (step 2); busy_o high t+1..t+10; done_o=1 only at t+11; loop_cnt_o=1.
- **Two loops.**
  - Stimulus: same config with loops_i=2.
  - Response: at t+11 step_o=0 with strobe, loop_cnt_o=1, no done_o; done_o at t+21; loop_cnt_o=2.
- **Infinite plus abort.**
  - Stimulus: loops_i=0, nsteps_i=1, dur[0]=3; abort_i asserted 50 cycles after trigger.
  - Response: a strobe every 4 cycles; IDLE the next cycle; busy_o=0; done_o never high; loop_cnt_o holds 12.
- **Priority and ignore rules.**
  - trig in IDLE -> no state change.
  - arm+trig together in IDLE -> ARMED only.
  - abort+trig together in ARMED -> IDLE.
  - Second arm during RUN -> ignored.
- **Shadowing and clamping.**
  - Write dur[1]=9 mid-run -> the current run keeps the old value; the next run uses 9.
  - nsteps_i=0 -> one step per loop.
  - nsteps_i=7 with NSTEPS=4 -> four steps.
- **Reset mid-run.** rst_i pulsed during step 2 -> next cycle all outputs 0, state IDLE, dur[] cleared; a subsequent trig without arm is ignored.
